// File: rtl/ecc_pkg.sv
// Shared types for the scalar multiplication controller.
// States, operation codes and the affine point bundle.
package ecc_pkg;

   localparam int ECC_N  = 231;
   localparam int ECC_KW = 231;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_DBL = 1'b1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SCAN,
      S_DBL,
      S_DWAIT,
      S_ADD,
      S_AWAIT,
      S_FIN
   } state_e;

   typedef struct packed {
      logic [ECC_N-1:0] x;
      logic [ECC_N-1:0] y;
      logic             inf;
   } ecc_point_t;

endpackage

// File: rtl/scalar_mult_ctrl_if.sv
// Request/response bus to the affine point add/double unit.
// master = controller side, slave = arithmetic unit side.
interface scalar_mult_ctrl_if #(
   parameter int n = 231
);
   logic         op_req;
   logic         op_dbl;
   logic [n-1:0] op_x1;
   logic [n-1:0] op_y1;
   logic [n-1:0] op_x2;
   logic [n-1:0] op_y2;
   logic         op_done;
   logic [n-1:0] op_x3;
   logic [n-1:0] op_y3;
   logic         op_inf3;

   modport master (
      output op_req, op_dbl, op_x1, op_y1, op_x2, op_y2,
      input  op_done, op_x3, op_y3, op_inf3
   );

   modport slave (
      input  op_req, op_dbl, op_x1, op_y1, op_x2, op_y2,
      output op_done, op_x3, op_y3, op_inf3
   );
endinterface

// File: rtl/ecc_op_timer.sv
// Watchdog for one outstanding point operation.
// Only instantiated when ECC_OP_TIMEOUT_EN is defined.
module ecc_op_timer #(
   parameter int TIMEOUT_CYC = 4096
) (
   input  logic clk,
   input  logic reset,
   input  logic start_i,
   input  logic run_i,
   output logic expired_o
);

   logic [31:0] cnt_q, cnt_d;

   // Count cycles since the request; restart on every request.
   always_comb begin
      cnt_d = cnt_q;
      if (start_i)
         cnt_d = 32'd1;
      else if (run_i)
         cnt_d = cnt_q + 32'd1;
   end

   // Counter register.
   always_ff @(posedge clk) begin
      if (reset)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   // Fire two cycles early so the FIN cycle plus the registered done
   // land exactly TIMEOUT_CYC cycles after op_req.
   assign expired_o = run_i && (cnt_q == 32'(TIMEOUT_CYC - 2));

endmodule

// File: rtl/scalar_mult_ctrl.sv
// Left-to-right double-and-add controller computing Q = k*P.
// Optional op watchdog: define ECC_OP_TIMEOUT_EN.
module scalar_mult_ctrl
   import ecc_pkg::*;
#(
   parameter int n           = ECC_N,
   parameter int KW          = ECC_KW,
   parameter int TIMEOUT_CYC = 4096
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [KW-1:0] k,
   input  logic [n-1:0]  px,
   input  logic [n-1:0]  py,
   output logic          busy,
   output logic          done,
   output logic [n-1:0]  qx,
   output logic [n-1:0]  qy,
   output logic          q_inf,
   output logic          err,
   scalar_mult_ctrl_if.master op
);

   localparam int IW = $clog2(KW);

   state_e        state_q, state_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [KW-1:0] k_q, k_d;
   logic [n-1:0]  px_q, px_d, py_q, py_d;
   ecc_point_t    r_q, r_d;
   logic          busy_q, busy_d, done_q, done_d;
   logic [n-1:0]  qx_q, qx_d, qy_q, qy_d;
   logic          qinf_q, qinf_d;
   logic          dbl_q, dbl_d;
   logic          err_q, err_d;
   logic          last, bit_set, waiting, expired;

   assign last    = (idx_q == '0);
   assign bit_set = k_q[idx_q];
   assign waiting = (state_q == S_DWAIT) || (state_q == S_AWAIT);

`ifdef ECC_OP_TIMEOUT_EN
   ecc_op_timer #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_timer (
      .clk       (clk),
      .reset     (reset),
      .start_i   (op.op_req),
      .run_i     (waiting),
      .expired_o (expired)
   );
`else
   assign expired = 1'b0;
`endif

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         k_q     <= '0;
         px_q    <= '0;
         py_q    <= '0;
         r_q     <= '{x: '0, y: '0, inf: 1'b1};
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         qx_q    <= '0;
         qy_q    <= '0;
         qinf_q  <= 1'b0;
         dbl_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         k_q     <= k_d;
         px_q    <= px_d;
         py_q    <= py_d;
         r_q     <= r_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         qx_q    <= qx_d;
         qy_q    <= qy_d;
         qinf_q  <= qinf_d;
         dbl_q   <= dbl_d;
         err_q   <= err_d;
      end
   end

   // Next-state: walk the scalar bits and sequence DBL/ADD.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      k_d     = k_q;
      px_d    = px_q;
      py_d    = py_q;
      r_d     = r_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      qx_d    = qx_q;
      qy_d    = qy_q;
      qinf_d  = qinf_q;
      dbl_d   = dbl_q;
      err_d   = err_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               k_d     = k;
               px_d    = px;
               py_d    = py;
               idx_d   = IW'(KW - 1);
               r_d.inf = 1'b1;
               busy_d  = 1'b1;
               err_d   = 1'b0;
               state_d = S_SCAN;
            end
         end
         S_SCAN: begin
            if (bit_set) begin
               r_d     = '{x: px_q, y: py_q, inf: 1'b0};
               state_d = last ? S_FIN : S_DBL;
               if (!last) idx_d = idx_q - 1'b1;
            end else if (last) begin
               state_d = S_FIN;
            end else begin
               idx_d = idx_q - 1'b1;
            end
         end
         S_DBL: begin
            dbl_d = OP_DBL;
            if (!r_q.inf) begin
               state_d = S_DWAIT;
            end else if (bit_set) begin
               state_d = S_ADD;
            end else begin
               state_d = last ? S_FIN : S_DBL;
               if (!last) idx_d = idx_q - 1'b1;
            end
         end
         S_DWAIT: begin
            if (op.op_done) begin
               r_d = '{x: op.op_x3, y: op.op_y3, inf: op.op_inf3};
               if (bit_set) begin
                  state_d = S_ADD;
               end else begin
                  state_d = last ? S_FIN : S_DBL;
                  if (!last) idx_d = idx_q - 1'b1;
               end
            end else if (expired) begin
               r_d.inf = 1'b1;
               err_d   = 1'b1;
               state_d = S_FIN;
            end
         end
         S_ADD: begin
            dbl_d = OP_ADD;
            if (r_q.inf) begin
               r_d     = '{x: px_q, y: py_q, inf: 1'b0};
               state_d = last ? S_FIN : S_DBL;
               if (!last) idx_d = idx_q - 1'b1;
            end else begin
               state_d = S_AWAIT;
            end
         end
         S_AWAIT: begin
            if (op.op_done) begin
               r_d = '{x: op.op_x3, y: op.op_y3, inf: op.op_inf3};
               state_d = last ? S_FIN : S_DBL;
               if (!last) idx_d = idx_q - 1'b1;
            end else if (expired) begin
               r_d.inf = 1'b1;
               err_d   = 1'b1;
               state_d = S_FIN;
            end
         end
         S_FIN: begin
            qx_d    = r_q.inf ? '0 : r_q.x;
            qy_d    = r_q.inf ? '0 : r_q.y;
            qinf_d  = r_q.inf;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs: request pulse and operand buses held through the wait.
   always_comb begin
      op.op_req = ((state_q == S_DBL) || (state_q == S_ADD)) && !r_q.inf;
      op.op_dbl = dbl_q;
      if (state_q == S_DBL) op.op_dbl = OP_DBL;
      if (state_q == S_ADD) op.op_dbl = OP_ADD;
      op.op_x1 = r_q.x;
      op.op_y1 = r_q.y;
      op.op_x2 = px_q;
      op.op_y2 = py_q;
   end

   assign busy  = busy_q;
   assign done  = done_q;
   assign qx    = qx_q;
   assign qy    = qy_q;
   assign q_inf = qinf_q;
   assign err   = err_q;

endmodule

// File: tb/tb_scalar_mult_ctrl.sv
// Directed bench for scalar_mult_ctrl on y^2 = x^3+2x+2 over GF(17), G=(5,1).
// Define ECC_OP_TIMEOUT_EN to also exercise the op watchdog.
module tb_scalar_mult_ctrl;
   import ecc_pkg::*;

   localparam int n  = ECC_N;
   localparam int KW = ECC_KW;
`ifdef ECC_OP_TIMEOUT_EN
   localparam int TO = 16;
`else
   localparam int TO = 4096;
`endif

   logic          clk = 1'b0;
   logic          reset, start;
   logic [KW-1:0] k;
   logic [n-1:0]  px, py, qx, qy;
   logic          busy, done, q_inf, err;

   scalar_mult_ctrl_if #(.n(n)) op_if ();

   scalar_mult_ctrl #(
      .n           (n),
      .KW          (KW),
      .TIMEOUT_CYC (TO)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .k     (k),
      .px    (px),
      .py    (py),
      .busy  (busy),
      .done  (done),
      .qx    (qx),
      .qy    (qy),
      .q_inf (q_inf),
      .err   (err),
      .op    (op_if)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int n_dbl = 0;
   int n_add = 0;
   int n_done = 0;
   bit model_en = 1'b1;

   task automatic chk(input string tag, input logic [255:0] obs,
                      input logic [255:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int md(input int a);
      return ((a % 17) + 17) % 17;
   endfunction

   function automatic int inv(input int a);
      for (int b = 1; b < 17; b++)
         if (md(a * b) == 1) return b;
      return 0;
   endfunction

   function automatic void pt_op(input bit dbl, input int x1, y1, x2, y2,
                                 output int x3, y3, output bit inf3);
      int lam;
      x3 = 0; y3 = 0; inf3 = 1'b0;
      if (dbl || (x1 == x2 && y1 == y2)) begin
         if (y1 == 0) begin inf3 = 1'b1; return; end
         lam = md(md(3 * x1 * x1 + 2) * inv(md(2 * y1)));
         x2 = x1;
      end else if (x1 == x2) begin
         inf3 = 1'b1;
         return;
      end else begin
         lam = md(md(y2 - y1) * inv(md(x2 - x1)));
      end
      x3 = md(lam * lam - x1 - x2);
      y3 = md(lam * (x1 - x3) - y1);
   endfunction

   // Arithmetic unit model with 7-cycle latency plus done/op monitors.
   initial begin
      int cnt = 0;
      int rx, ry;
      bit rinf;
      op_if.op_done = 1'b0;
      op_if.op_x3   = '0;
      op_if.op_y3   = '0;
      op_if.op_inf3 = 1'b0;
      forever begin
         @(negedge clk);
         if (done) n_done++;
         op_if.op_done = 1'b0;
         if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
               op_if.op_done = 1'b1;
               op_if.op_x3   = n'(rx);
               op_if.op_y3   = n'(ry);
               op_if.op_inf3 = rinf;
            end
         end else if (op_if.op_req && model_en) begin
            if (op_if.op_dbl) n_dbl++;
            else n_add++;
            pt_op(op_if.op_dbl, int'(op_if.op_x1[7:0]), int'(op_if.op_y1[7:0]),
                  int'(op_if.op_x2[7:0]), int'(op_if.op_y2[7:0]), rx, ry, rinf);
            cnt = 6;
         end
      end
   end

   task automatic run_k(input string tag, input logic [KW-1:0] kv,
                        input int ex, ey, input bit einf,
                        input int edbl, eadd, elat, input bit hold);
      int cyc, d0, a0, n0;
      @(negedge clk);
      d0 = n_dbl; a0 = n_add; n0 = n_done;
      start = 1'b1; k = kv; px = 5; py = 1;
      @(negedge clk);
      cyc = 0;
      if (!hold) start = 1'b0;
      chk({tag, ".busy"}, busy, 1);
      while (!done && cyc < 3000) begin
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      chk({tag, ".done"}, done, 1);
      if (elat >= 0) chk({tag, ".lat"}, cyc, elat);
      chk({tag, ".qx"}, qx, ex);
      chk({tag, ".qy"}, qy, ey);
      chk({tag, ".qinf"}, q_inf, einf);
      chk({tag, ".busy_end"}, busy, 0);
      chk({tag, ".err"}, err, 0);
      repeat (3) @(negedge clk);
      chk({tag, ".ndbl"}, n_dbl - d0, edbl);
      chk({tag, ".nadd"}, n_add - a0, eadd);
      chk({tag, ".ndone"}, n_done - n0, 1);
   endtask

   initial begin
      int cyc, n0;
      reset = 1'b1; start = 1'b0; k = '0; px = '0; py = '0;
      repeat (3) @(negedge clk);
      chk("rst.busy", busy, 0);
      chk("rst.done", done, 0);
      chk("rst.req", op_if.op_req, 0);
      chk("rst.dbl", op_if.op_dbl, 0);
      chk("rst.qinf", q_inf, 0);
      chk("rst.err", err, 0);
      chk("rst.qx", qx, 0);
      chk("rst.x1", op_if.op_x1, 0);
      reset = 1'b0;

      run_k("k1", 1, 5, 1, 0, 0, 0, 232, 0);
      run_k("k3", 3, 10, 6, 0, 1, 1, 245, 0);
      run_k("k19", 19, 0, 0, 1, 4, 2, -1, 0);
      run_k("k0", 0, 0, 0, 1, 0, 0, 232, 1);

      // Reset while the first DBL of k=19 is outstanding.
      @(negedge clk);
      start = 1'b1; k = 19; px = 5; py = 1;
      @(negedge clk);
      start = 1'b0;
      cyc = 0;
      while (!op_if.op_req && cyc < 1000) begin
         @(negedge clk);
         cyc++;
      end
      chk("abort.req_seen", op_if.op_req, 1);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("abort.busy", busy, 0);
      chk("abort.req", op_if.op_req, 0);
      reset = 1'b0;
      n0 = n_done;
      repeat (12) @(negedge clk);
      chk("abort.ndone", n_done - n0, 0);
      chk("abort.busy2", busy, 0);
      run_k("k2", 2, 6, 3, 0, 1, 0, -1, 0);

`ifdef ECC_OP_TIMEOUT_EN
      model_en = 1'b0;
      @(negedge clk);
      start = 1'b1; k = 3; px = 5; py = 1;
      @(negedge clk);
      start = 1'b0;
      cyc = 0;
      while (!op_if.op_req && cyc < 1000) begin
         @(negedge clk);
         cyc++;
      end
      chk("to.req_seen", op_if.op_req, 1);
      cyc = 0;
      while (!done && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      chk("to.done", done, 1);
      chk("to.lat", cyc, 16);
      chk("to.err", err, 1);
      chk("to.qinf", q_inf, 1);
      chk("to.qx", qx, 0);
      model_en = 1'b1;
      repeat (3) @(negedge clk);
      chk("to.err_hold", err, 1);
      run_k("k1b", 1, 5, 1, 0, 0, 0, 232, 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
